// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared FSM state encoding and default widths for mem_access_ctrl
package mem_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_ADDR_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD_A = 3'd2,
    RD_D = 3'd3,
    RESP = 3'd4
  } state_t;

endpackage

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - single-request memory access FSM with registered memory strobes
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_w,
  output logic                  mem_r,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
  logic                  mem_w_q, mem_w_d;
  logic                  mem_r_q, mem_r_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      mem_w_q      <= 1'b0;
      mem_r_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      mem_w_q      <= mem_w_d;
      mem_r_q      <= mem_r_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Strobes default low every cycle; address/data hold their last value.
  always_comb begin
    state_d      = state_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    mem_w_d      = 1'b0;
    mem_r_d      = 1'b0;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          mem_addr_d = req_addr;
          if (req_we) begin
            state_d    = WR;
            mem_data_d = req_wdata;
            mem_w_d    = 1'b1;
          end else begin
            state_d = RD_A;
            mem_r_d = 1'b1;
          end
        end
      end
      WR: state_d = IDLE;
      RD_A: begin
        state_d = RD_D;
        mem_r_d = 1'b1;
      end
      // mem_q settled at the negedge inside RD_D.
      RD_D: begin
        state_d      = RESP;
        resp_rdata_d = mem_q;
        resp_valid_d = 1'b1;
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign mem_w      = mem_w_q;
  assign mem_r      = mem_r_q;

endmodule
